// File: rtl/mag_event_detector.sv
// Moving average, running peak and hysteresis event detector on the magnitude stream.
// One-cycle registered latency; no backpressure, a sample is taken whenever ena && mag_valid.
module mag_event_detector #(
  parameter int WIDTH     = 8,
  parameter int AVG_LOG2  = 3,
  parameter int HI_THRESH = 180,
  parameter int LO_THRESH = 150,
  parameter int HOLD      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             mag_valid,
  input  logic [WIDTH-1:0] mag_in,
  input  logic             clear,
  output logic [WIDTH-1:0] avg_out,
  output logic             avg_valid,
  output logic [WIDTH-1:0] peak_out,
  output logic             event_out,
  output logic             event_pulse
);

  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int SW    = WIDTH + AVG_LOG2;
  localparam int FW    = AVG_LOG2 + 1;
  localparam int CW    = (HOLD > 1) ? $clog2(HOLD + 1) : 1;

  localparam logic [WIDTH-1:0] HI     = WIDTH'(HI_THRESH);
  localparam logic [WIDTH-1:0] LO     = WIDTH'(LO_THRESH);
  localparam logic [FW-1:0]    FULL   = FW'(DEPTH);
  localparam logic [CW-1:0]    HOLD_C = CW'(HOLD);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ARMING = 2'd1;
  localparam logic [1:0] ACTIVE = 2'd2;

  logic [DEPTH-1:0][WIDTH-1:0] win;
  logic [SW-1:0]               sum;
  logic [SW-1:0]               sum_next;
  logic [FW-1:0]               fill_cnt;
  logic [CW-1:0]               arm_cnt;
  logic [CW-1:0]               arm_cnt_inc;
  logic [1:0]                  state;
  logic                        accept;
  logic                        do_clear;
  logic                        hi_hit;
  logic                        below_lo;
  logic                        hold_done;

  assign do_clear    = ena && clear;
  assign accept      = ena && mag_valid && !clear;
  assign hi_hit      = mag_in >= HI;
  assign below_lo    = mag_in < LO;
  assign arm_cnt_inc = arm_cnt + 1'b1;
  assign hold_done   = arm_cnt_inc == HOLD_C;
  // Window slots start at zero, so subtracting the oldest entry is valid from the first sample.
  assign sum_next    = sum + SW'(mag_in) - SW'(win[DEPTH-1]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win         <= '0;
      sum         <= '0;
      fill_cnt    <= '0;
      avg_out     <= '0;
      avg_valid   <= 1'b0;
      peak_out    <= '0;
      state       <= IDLE;
      arm_cnt     <= '0;
      event_out   <= 1'b0;
      event_pulse <= 1'b0;
    end else if (do_clear) begin
      win         <= '0;
      sum         <= '0;
      fill_cnt    <= '0;
      avg_out     <= '0;
      avg_valid   <= 1'b0;
      peak_out    <= '0;
      state       <= IDLE;
      arm_cnt     <= '0;
      event_out   <= 1'b0;
      event_pulse <= 1'b0;
    end else begin
      event_pulse <= 1'b0;
      if (accept) begin
        win     <= {win[DEPTH-2:0], mag_in};
        sum     <= sum_next;
        avg_out <= sum_next[SW-1:AVG_LOG2];
        if (fill_cnt != FULL) fill_cnt <= fill_cnt + 1'b1;
        if (fill_cnt == FULL - 1'b1) avg_valid <= 1'b1;
        if (mag_in > peak_out) peak_out <= mag_in;

        case (state)
          IDLE: begin
            if (hi_hit) begin
              arm_cnt <= CW'(1);
              if (HOLD == 1) begin
                state       <= ACTIVE;
                event_out   <= 1'b1;
                event_pulse <= 1'b1;
              end else begin
                state <= ARMING;
              end
            end
          end
          ARMING: begin
            // Any sub-threshold sample breaks the run; there is no partial credit.
            if (hi_hit) begin
              if (hold_done) begin
                state       <= ACTIVE;
                event_out   <= 1'b1;
                event_pulse <= 1'b1;
                arm_cnt     <= '0;
              end else begin
                arm_cnt <= arm_cnt_inc;
              end
            end else begin
              state   <= IDLE;
              arm_cnt <= '0;
            end
          end
          ACTIVE: begin
            if (below_lo) begin
              state     <= IDLE;
              event_out <= 1'b0;
            end
          end
          default: begin
            state     <= IDLE;
            arm_cnt   <= '0;
            event_out <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mag_event_detector.sv
// Directed bench for mag_event_detector: queue-based reference model checked every cycle,
// plus hand-computed literal expectations along the test sequence.
module tb_mag_event_detector;

  localparam int HI   = 180;
  localparam int LO   = 150;
  localparam int HOLD = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic       mag_valid;
  logic       clear;
  logic [7:0] mag_in;
  logic [7:0] avg_out;
  logic [7:0] peak_out;
  logic       avg_valid;
  logic       event_out;
  logic       event_pulse;

  logic       ena1;
  logic       vld1;
  logic [7:0] mag1;
  logic [7:0] avg1;
  logic [7:0] peak1;
  logic       avgv1;
  logic       ev1;
  logic       pulse1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mag_event_detector dut (
    .clk(clk), .rst(rst), .ena(ena), .mag_valid(mag_valid), .mag_in(mag_in), .clear(clear),
    .avg_out(avg_out), .avg_valid(avg_valid), .peak_out(peak_out),
    .event_out(event_out), .event_pulse(event_pulse)
  );

  mag_event_detector #(.HOLD(1)) dut1 (
    .clk(clk), .rst(rst), .ena(ena1), .mag_valid(vld1), .mag_in(mag1), .clear(1'b0),
    .avg_out(avg1), .avg_valid(avgv1), .peak_out(peak1),
    .event_out(ev1), .event_pulse(pulse1)
  );

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: last 8 accepted samples, max since clear, run length of high samples.
  int q[$];
  int m_peak;
  int m_run;
  int m_cnt;
  bit m_active;
  bit m_pulse;

  function automatic int m_avg();
    int s = 0;
    foreach (q[i]) s += q[i];
    return s / 8;
  endfunction

  always @(posedge clk or posedge rst) begin
    m_pulse = 1'b0;
    if (rst || (ena && clear)) begin
      q.delete();
      m_peak   = 0;
      m_run    = 0;
      m_cnt    = 0;
      m_active = 1'b0;
    end else if (ena && mag_valid) begin
      q.push_back(int'(mag_in));
      if (q.size() > 8) q = q[1:$];
      m_cnt++;
      if (int'(mag_in) > m_peak) m_peak = int'(mag_in);
      if (m_active) begin
        if (int'(mag_in) < LO) m_active = 1'b0;
      end else if (int'(mag_in) >= HI) begin
        m_run++;
        if (m_run == HOLD) begin
          m_active = 1'b1;
          m_pulse  = 1'b1;
          m_run    = 0;
        end
      end else begin
        m_run = 0;
      end
    end
  end

  always @(negedge clk) begin
    check("model_avg_out", avg_out, m_avg());
    check("model_avg_valid", avg_valid, (m_cnt >= 8) ? 1 : 0);
    check("model_peak_out", peak_out, m_peak);
    check("model_event_out", event_out, m_active);
    check("model_event_pulse", event_pulse, m_pulse);
  end

  task automatic cyc(input logic e, input logic v, input logic [7:0] m, input logic c);
    @(negedge clk);
    ena       = e;
    mag_valid = v;
    mag_in    = m;
    clear     = c;
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_avg"}, avg_out, 0);
    check({tag, "_valid"}, avg_valid, 0);
    check({tag, "_peak"}, peak_out, 0);
    check({tag, "_event"}, event_out, 0);
    check({tag, "_pulse"}, event_pulse, 0);
  endtask

  initial begin
    rst = 1'b1; ena = 1'b0; mag_valid = 1'b0; mag_in = '0; clear = 1'b0;
    ena1 = 1'b0; vld1 = 1'b0; mag1 = '0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    repeat (3) cyc(1'b1, 1'b0, 8'd0, 1'b0);
    check_zero("idle");

    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 1'b1, 8'd80, 1'b0);
      check("ramp_up_avg", avg_out, 10 * (i + 1));
      check("ramp_up_valid", avg_valid, (i == 7) ? 1 : 0);
    end
    for (int j = 0; j < 8; j++) begin
      cyc(1'b1, 1'b1, 8'd0, 1'b0);
      check("ramp_down_avg", avg_out, 70 - 10 * j);
      check("ramp_down_valid", avg_valid, 1);
    end
    check("ramp_peak", peak_out, 80);

    cyc(1'b1, 1'b1, 8'd12, 1'b0);
    cyc(1'b1, 1'b1, 8'd200, 1'b0);
    cyc(1'b1, 1'b1, 8'd199, 1'b0);
    check("peak_after_199", peak_out, 200);
    cyc(1'b1, 1'b1, 8'd200, 1'b0);
    check("peak_equal", peak_out, 200);
    cyc(1'b1, 1'b1, 8'd250, 1'b1);
    check_zero("clear");

    cyc(1'b1, 1'b1, 8'd190, 1'b0);
    cyc(1'b1, 1'b1, 8'd185, 1'b0);
    repeat (3) cyc(1'b1, 1'b0, 8'd0, 1'b0);
    cyc(1'b1, 1'b1, 8'd180, 1'b0);
    check("arm3_pulse", event_pulse, 0);
    check("arm3_event", event_out, 0);
    cyc(1'b1, 1'b1, 8'd181, 1'b0);
    check("arm4_pulse", event_pulse, 1);
    check("arm4_event", event_out, 1);
    cyc(1'b1, 1'b0, 8'd0, 1'b0);
    check("post_pulse", event_pulse, 0);
    check("post_event", event_out, 1);

    cyc(1'b1, 1'b1, 8'd160, 1'b0);
    check("hyst_160", event_out, 1);
    cyc(1'b1, 1'b1, 8'd150, 1'b0);
    check("hyst_150", event_out, 1);
    cyc(1'b1, 1'b1, 8'd149, 1'b0);
    check("hyst_149_event", event_out, 0);
    check("hyst_149_pulse", event_pulse, 0);
    cyc(1'b1, 1'b1, 8'd175, 1'b0);
    check("hyst_175", event_out, 0);

    cyc(1'b1, 1'b1, 8'd190, 1'b0);
    cyc(1'b1, 1'b1, 8'd190, 1'b0);
    cyc(1'b1, 1'b1, 8'd179, 1'b0);
    cyc(1'b1, 1'b1, 8'd190, 1'b0);
    check("broken_run_event", event_out, 0);
    check("broken_run_pulse", event_pulse, 0);

    // Window now holds 160,150,149,175,190,190,179,190: sum 1383 -> 172.
    for (int k = 0; k < 10; k++) begin
      cyc(1'b0, 1'b1, 8'd255, 1'b1);
      check("gate_avg", avg_out, 172);
      check("gate_peak", peak_out, 190);
      check("gate_valid", avg_valid, 1);
      check("gate_event", event_out, 0);
    end

    cyc(1'b1, 1'b1, 8'd200, 1'b0);
    cyc(1'b1, 1'b1, 8'd200, 1'b0);
    cyc(1'b1, 1'b1, 8'd200, 1'b0);
    check("prereset_pulse", event_pulse, 1);
    check("prereset_event", event_out, 1);
    #2;
    rst = 1'b1;
    #1;
    check_zero("midreset");
    @(negedge clk);
    rst = 1'b0; ena = 1'b0; mag_valid = 1'b0; clear = 1'b0;
    repeat (3) cyc(1'b1, 1'b0, 8'd0, 1'b0);
    check_zero("postreset");

    @(negedge clk);
    ena1 = 1'b1; vld1 = 1'b1; mag1 = 8'd179;
    @(posedge clk);
    #1;
    check("hold1_179_pulse", pulse1, 0);
    @(negedge clk);
    mag1 = 8'd180;
    @(posedge clk);
    #1;
    check("hold1_180_pulse", pulse1, 1);
    check("hold1_180_event", ev1, 1);
    @(negedge clk);
    vld1 = 1'b0;
    @(posedge clk);
    #1;
    check("hold1_after_pulse", pulse1, 0);
    check("hold1_after_event", ev1, 1);
    check("hold1_peak", peak1, 180);
    check("hold1_avg", avg1, 44);
    check("hold1_valid", avgv1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
